// File: rtl/bus_dev_fifo_pkg.sv
// Shared definitions for the bus device FIFO block: ID width, the default
// broadcast ID, and the destination-field extractor used by the RX filter.
package bus_dev_fifo_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Widest packet the extractor accepts; callers zero-extend up to this width.
  localparam int MAX_PCKG_SZ = 256;

  // Return the top ID_W bits of a pckg_sz-wide packet held in the low bits of pkt.
  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PCKG_SZ-1:0] pkt,
                                               input int pckg_sz);
    logic [MAX_PCKG_SZ-1:0] shifted;
    shifted = pkt >> (pckg_sz - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_dev_fifo_core.sv
// First-word-fall-through FIFO with occupancy count, full/empty flags and
// simultaneous enqueue/dequeue. The head is visible on rd_data with no read
// latency and rd_data reads as zero while the FIFO is empty.
module bus_fifo_core #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_rd_s;
  logic          do_wr_s;

  // Flags come straight from the registered count.
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

  // A dequeue needs data; an enqueue needs room, which a same-cycle dequeue provides.
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);

  assign rd_data = empty ? {W{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; intentionally not reset, stale data is masked by empty.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/bus_dev_fifo.sv
// Bus device FIFO pair: a TX queue from host to bus and an RX queue from bus
// to host. Received packets are filtered on destination ID; misrouted packets
// are counted (saturating) and packets dropped on a full RX queue set a
// sticky overflow flag.
module bus_dev_fifo
  import bus_dev_fifo_pkg::*;
#(
  parameter int              PCKG_SZ   = 16,
  parameter int              DEPTH     = 8,
  parameter logic [ID_W-1:0] DEV_ID    = 8'h00,
  parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [PCKG_SZ-1:0]       wr_data,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     pndng,
  output logic [PCKG_SZ-1:0]       d_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [PCKG_SZ-1:0]       d_push,
  input  logic                     rd_en,
  output logic [PCKG_SZ-1:0]       rd_data,
  output logic                     rx_empty,
  output logic                     rx_overflow,
  output logic [7:0]               misroute_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   tx_empty_s;
  logic                   rx_full_s;
  logic [CW-1:0]          rx_count_unused_s;
  logic [MAX_PCKG_SZ-1:0] push_wide_s;
  logic [ID_W-1:0]        dest_s;
  logic                   match_s;
  logic                   accept_s;
  logic                   drop_s;
  logic                   misroute_s;
  logic                   rx_overflow_r;
  logic [7:0]             misroute_r;

  bus_fifo_core #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (d_pop),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty_s)
  );

  assign pndng = ~tx_empty_s;

  assign push_wide_s = {{(MAX_PCKG_SZ - PCKG_SZ){1'b0}}, d_push};
  assign dest_s      = get_dest(push_wide_s, PCKG_SZ);
  assign match_s     = (dest_s == DEV_ID) || (dest_s == BROADCAST);
  assign accept_s    = push & match_s;
  assign misroute_s  = push & ~match_s;
  // A same-cycle read frees a slot, so only a full queue without rd_en drops.
  assign drop_s      = accept_s & rx_full_s & ~rd_en;

  bus_fifo_core #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (accept_s),
    .wr_data (d_push),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (rx_count_unused_s),
    .full    (rx_full_s),
    .empty   (rx_empty)
  );

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overflow_r <= 1'b0;
    end else if (drop_s) begin
      rx_overflow_r <= 1'b1;
    end
  end

  // Saturating count of packets addressed to some other device.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_r <= 8'h00;
    end else if (misroute_s && (misroute_r != 8'hFF)) begin
      misroute_r <= misroute_r + 8'h01;
    end
  end

  assign rx_overflow  = rx_overflow_r;
  assign misroute_cnt = misroute_r;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed self-checking bench for bus_dev_fifo (DEPTH=8, DEV_ID=3).
module tb_bus_dev_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic [15:0] d_pop;
  logic        pop;
  logic        push;
  logic [15:0] d_push;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rx_empty;
  logic        rx_overflow;
  logic [7:0]  misroute_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bus_dev_fifo #(.PCKG_SZ(16), .DEPTH(8), .DEV_ID(8'h03), .BROADCAST(8'hFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_full      (tx_full),
    .tx_count     (tx_count),
    .pndng        (pndng),
    .d_pop        (d_pop),
    .pop          (pop),
    .push         (push),
    .d_push       (d_push),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rx_empty     (rx_empty),
    .rx_overflow  (rx_overflow),
    .misroute_cnt (misroute_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 16'h0; pop = 1'b0;
    push = 1'b0; d_push = 16'h0; rd_en = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if ({tx_count, tx_full, pndng, rx_empty, rx_overflow} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_flags got %b exp %b", {tx_count, tx_full, pndng, rx_empty, rx_overflow}, 8'b0000_0010);
    else pass_cnt++;
    total_cnt++;
    if ({d_pop, rd_data, misroute_cnt} !== 40'h0)
      $display("FAIL reset_data got %h exp %h", {d_pop, rd_data, misroute_cnt}, 40'h0);
    else pass_cnt++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_tx_basic();
    wr_en = 1'b1; wr_data = 16'h0155; cyc();
    total_cnt++;
    if (pndng !== 1'b1 || d_pop !== 16'h0155 || tx_count !== 4'd1)
      $display("FAIL tx_first got pndng=%b d_pop=%h cnt=%0d exp 1 0155 1", pndng, d_pop, tx_count);
    else pass_cnt++;
    wr_data = 16'h02AA; cyc();
    wr_en = 1'b0;
    total_cnt++;
    if (tx_count !== 4'd2) $display("FAIL tx_two got %0d exp 2", tx_count); else pass_cnt++;
    pop = 1'b1; cyc(); pop = 1'b0;
    total_cnt++;
    if (d_pop !== 16'h02AA || tx_count !== 4'd1)
      $display("FAIL tx_pop got d_pop=%h cnt=%0d exp 02aa 1", d_pop, tx_count);
    else pass_cnt++;
    wr_en = 1'b1; wr_data = 16'h0333; pop = 1'b1; cyc(); wr_en = 1'b0; pop = 1'b0;
    total_cnt++;
    if (d_pop !== 16'h0333 || tx_count !== 4'd1)
      $display("FAIL tx_wr_pop_mid got d_pop=%h cnt=%0d exp 0333 1", d_pop, tx_count);
    else pass_cnt++;
    pop = 1'b1; cyc(); pop = 1'b0;
    total_cnt++;
    if (pndng !== 1'b0 || d_pop !== 16'h0000 || tx_count !== 4'd0)
      $display("FAIL tx_drain got pndng=%b d_pop=%h cnt=%0d exp 0 0000 0", pndng, d_pop, tx_count);
    else pass_cnt++;
    wr_en = 1'b1; wr_data = 16'h0777; pop = 1'b1; cyc(); wr_en = 1'b0; pop = 1'b0;
    total_cnt++;
    if (d_pop !== 16'h0777 || tx_count !== 4'd1)
      $display("FAIL tx_pop_empty got d_pop=%h cnt=%0d exp 0777 1", d_pop, tx_count);
    else pass_cnt++;
    pop = 1'b1; cyc(); pop = 1'b0;
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 16'h1000 + 16'(i); cyc();
    end
    wr_en = 1'b0;
    total_cnt++;
    if (tx_count !== 4'd8 || tx_full !== 1'b1 || d_pop !== 16'h1000)
      $display("FAIL tx_full got cnt=%0d full=%b d_pop=%h exp 8 1 1000", tx_count, tx_full, d_pop);
    else pass_cnt++;
    wr_en = 1'b1; wr_data = 16'hABCD; pop = 1'b1; cyc(); wr_en = 1'b0; pop = 1'b0;
    total_cnt++;
    if (tx_count !== 4'd8 || tx_full !== 1'b1 || d_pop !== 16'h1001)
      $display("FAIL tx_full_wr_pop got cnt=%0d full=%b d_pop=%h exp 8 1 1001", tx_count, tx_full, d_pop);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      pop = 1'b1; cyc();
    end
    pop = 1'b0;
    total_cnt++;
    if (d_pop !== 16'hABCD || tx_count !== 4'd1)
      $display("FAIL tx_tail got d_pop=%h cnt=%0d exp abcd 1", d_pop, tx_count);
    else pass_cnt++;
    pop = 1'b1; cyc(); pop = 1'b0;
    total_cnt++;
    if (pndng !== 1'b0) $display("FAIL tx_full_drain got pndng=%b exp 0", pndng); else pass_cnt++;
  endtask

  task automatic test_rx_filter();
    push = 1'b1;
    d_push = 16'h0311; cyc();
    d_push = 16'hFF22; cyc();
    d_push = 16'h0533; cyc();
    push = 1'b0;
    total_cnt++;
    if (rd_data !== 16'h0311 || rx_empty !== 1'b0 || misroute_cnt !== 8'd1)
      $display("FAIL rx_filter got rd=%h empty=%b mis=%0d exp 0311 0 1", rd_data, rx_empty, misroute_cnt);
    else pass_cnt++;
    rd_en = 1'b1; cyc();
    total_cnt++;
    if (rd_data !== 16'hFF22) $display("FAIL rx_bcast got %h exp ff22", rd_data); else pass_cnt++;
    cyc();
    total_cnt++;
    if (rx_empty !== 1'b1 || rd_data !== 16'h0000)
      $display("FAIL rx_drain got empty=%b rd=%h exp 1 0000", rx_empty, rd_data);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (rx_empty !== 1'b1) $display("FAIL rx_rd_empty got empty=%b exp 1", rx_empty); else pass_cnt++;
    push = 1'b1; d_push = 16'h0344; cyc(); push = 1'b0; rd_en = 1'b0;
    total_cnt++;
    if (rx_empty !== 1'b0 || rd_data !== 16'h0344)
      $display("FAIL rx_push_rd_empty got empty=%b rd=%h exp 0 0344", rx_empty, rd_data);
    else pass_cnt++;
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [15:0] exp_v;
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; d_push = 16'h0300 + 16'(i); cyc();
    end
    push = 1'b0;
    total_cnt++;
    if (rx_overflow !== 1'b1 || rd_data !== 16'h0300)
      $display("FAIL rx_overflow got ovf=%b rd=%h exp 1 0300", rx_overflow, rd_data);
    else pass_cnt++;
    push = 1'b1; d_push = 16'h03AA; rd_en = 1'b1; cyc(); push = 1'b0; rd_en = 1'b0;
    total_cnt++;
    if (rd_data !== 16'h0301) $display("FAIL rx_full_push_rd got %h exp 0301", rd_data); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      exp_v = (i < 7) ? (16'h0301 + 16'(i)) : 16'h03AA;
      total_cnt++;
      if (rd_data !== exp_v) $display("FAIL rx_order[%0d] got %h exp %h", i, rd_data, exp_v);
      else pass_cnt++;
      rd_en = 1'b1; cyc(); rd_en = 1'b0;
    end
    total_cnt++;
    if (rx_empty !== 1'b1 || rx_overflow !== 1'b1)
      $display("FAIL rx_sticky got empty=%b ovf=%b exp 1 1", rx_empty, rx_overflow);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    push = 1'b1; d_push = 16'h0700;
    for (int i = 0; i < 300; i++) cyc();
    push = 1'b0;
    total_cnt++;
    if (misroute_cnt !== 8'd255 || rx_empty !== 1'b1)
      $display("FAIL misroute_sat got cnt=%0d empty=%b exp 255 1", misroute_cnt, rx_empty);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 16'h2000 + 16'(i); cyc();
    end
    wr_en = 1'b0;
    push = 1'b1; d_push = 16'h0355; cyc(); push = 1'b0;
    total_cnt++;
    if (tx_count !== 4'd5 || rx_empty !== 1'b0)
      $display("FAIL pre_reset got cnt=%0d rx_empty=%b exp 5 0", tx_count, rx_empty);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({tx_count, tx_full, pndng, rx_empty, rx_overflow} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL async_flags got %b exp %b", {tx_count, tx_full, pndng, rx_empty, rx_overflow}, 8'b0000_0010);
    else pass_cnt++;
    total_cnt++;
    if ({d_pop, rd_data, misroute_cnt} !== 40'h0)
      $display("FAIL async_data got %h exp %h", {d_pop, rd_data, misroute_cnt}, 40'h0);
    else pass_cnt++;
    cyc();
    reset = 1'b0;
    cyc();
    wr_en = 1'b1; wr_data = 16'h4242; cyc(); wr_en = 1'b0;
    total_cnt++;
    if (tx_count !== 4'd1 || d_pop !== 16'h4242)
      $display("FAIL post_reset_wr got cnt=%0d d_pop=%h exp 1 4242", tx_count, d_pop);
    else pass_cnt++;
    pop = 1'b1; cyc(); pop = 1'b0;
    total_cnt++;
    if (pndng !== 1'b0 || tx_count !== 4'd0)
      $display("FAIL post_reset_pop got pndng=%b cnt=%0d exp 0 0", pndng, tx_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_filter();
    test_rx_overflow();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
